// File: rtl/alu_pkg.sv
// Shared definitions for the ALU multiplier self-test: FSM states, sweep
// constants, the operand code order and a sign-magnitude packing helper.
package alu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_CHECK,
      ST_DONE
   } sweep_state_e;

   localparam int MAG_MAX   = 3;
   localparam int NUM_PAIRS = 49;
   localparam int NUM_CODES = 2 * MAG_MAX + 1;

   // Entry 0 is -3, entry 6 is +3; code 100 (-0) is deliberately absent.
   localparam logic [NUM_CODES-1:0][2:0] OP_ORDER = {
      3'b011, 3'b010, 3'b001, 3'b000, 3'b101, 3'b110, 3'b111
   };

   function automatic logic [4:0] sm5_pack(input logic neg, input logic [3:0] mag);
      return {neg, mag};
   endfunction

endpackage

// File: rtl/mul_golden.sv
// Combinational reference product for 3-bit sign-magnitude operands.
// The zero flag lets the checker accept either sign on a zero result.
module mul_golden
   import alu_pkg::*;
(
   input  logic [2:0] a_i,
   input  logic [2:0] b_i,
   output logic [4:0] prod_o,
   output logic       zero_o
);

   logic [3:0] mag;

   always_comb begin
      mag    = {2'b00, a_i[1:0]} * {2'b00, b_i[1:0]};
      prod_o = sm5_pack(a_i[2] ^ b_i[2], mag);
      zero_o = (mag == 4'd0);
   end

endmodule

// File: rtl/mul_sweep_checker.sv
// Power-on self-test sequencer: sweeps every operand pair in -3..+3 through the
// external multiplier, compares against mul_golden and keeps pass/fail stats.
module mul_sweep_checker
   import alu_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [2:0]  a_out,
   output logic [2:0]  b_out,
   input  logic [4:0]  r_in,
   output logic        busy,
   output logic        done,
   output logic        err_pulse,
   output logic [5:0]  pass_cnt,
   output logic [5:0]  fail_cnt,
   output logic [10:0] first_fail
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [2:0] LAST_IDX    = 3'(NUM_CODES - 1);

   sweep_state_e state_q, state_d;
   logic [3:0]   settle_q, settle_d;
   logic [2:0]   idx_a_q, idx_a_d;
   logic [2:0]   idx_b_q, idx_b_d;
   logic [5:0]   pass_q, pass_d;
   logic [5:0]   fail_q, fail_d;
   logic [10:0]  first_q, first_d;
   logic         err_q, err_d;

   logic [4:0]   golden;
   logic         golden_zero;
   logic         match;

   // Operands read 000 until the first sweep starts, then follow the indices.
   always_comb begin
      a_out = 3'b000;
      b_out = 3'b000;
      if (state_q != ST_IDLE) begin
         a_out = OP_ORDER[idx_a_q];
         b_out = OP_ORDER[idx_b_q];
      end
   end

   mul_golden u_golden (
      .a_i    (a_out),
      .b_i    (b_out),
      .prod_o (golden),
      .zero_o (golden_zero)
   );

   // A zero product matches regardless of the sign bit the multiplier returns.
   always_comb begin
      match = golden_zero ? (r_in[3:0] == 4'd0) : (r_in == golden);
   end

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      idx_a_d  = idx_a_q;
      idx_b_d  = idx_b_q;
      pass_d   = pass_q;
      fail_d   = fail_q;
      first_d  = first_q;
      err_d    = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d  = ST_DRIVE;
               settle_d = SETTLE_LOAD;
               idx_a_d  = 3'd0;
               idx_b_d  = 3'd0;
               pass_d   = 6'd0;
               fail_d   = 6'd0;
               first_d  = 11'd0;
            end
         end

         ST_DRIVE: begin
            if (settle_q == 4'd0) begin
               state_d = ST_CHECK;
            end else begin
               settle_d = settle_q - 4'd1;
            end
         end

         ST_CHECK: begin
            if (match) begin
               pass_d = pass_q + 6'd1;
            end else begin
               fail_d = fail_q + 6'd1;
               err_d  = 1'b1;
               if (fail_q == 6'd0) begin
                  first_d = {a_out, b_out, r_in};
               end
            end

            // B is the inner loop; the sweep ends after (+3, +3).
            if ((idx_a_q == LAST_IDX) && (idx_b_q == LAST_IDX)) begin
               state_d = ST_DONE;
            end else begin
               state_d  = ST_DRIVE;
               settle_d = SETTLE_LOAD;
               if (idx_b_q == LAST_IDX) begin
                  idx_b_d = 3'd0;
                  idx_a_d = idx_a_q + 3'd1;
               end else begin
                  idx_b_d = idx_b_q + 3'd1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         settle_q <= 4'd0;
         idx_a_q  <= 3'd0;
         idx_b_q  <= 3'd0;
         pass_q   <= 6'd0;
         fail_q   <= 6'd0;
         first_q  <= 11'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         idx_a_q  <= idx_a_d;
         idx_b_q  <= idx_b_d;
         pass_q   <= pass_d;
         fail_q   <= fail_d;
         first_q  <= first_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      busy       = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
      done       = (state_q == ST_DONE);
      err_pulse  = err_q;
      pass_cnt   = pass_q;
      fail_cnt   = fail_q;
      first_fail = first_q;
   end

endmodule

// File: tb/tb_mul_sweep_checker.sv
// Directed bench for mul_sweep_checker: a behavioural multiplier with selectable
// fault stubs feeds two instances (settle 2 and settle 1).
module tb_mul_sweep_checker;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start1 = 1'b0;
   logic        start2 = 1'b0;
   logic [2:0]  a1, b1, a2, b2;
   logic [4:0]  r1, r2;
   logic        busy1, done1, err1, busy2, done2, err2;
   logic [5:0]  pass1, fail1, pass2, fail2;
   logic [10:0] first1, first2;

   logic [2:0]  selA, selB;
   logic        selBusy, selDone, selErr;
   logic [5:0]  selPass, selFail;
   logic [10:0] selFirst;

   int mode = 0;
   int sel = 2;
   int vecCount = 0;
   int missCount = 0;
   int len, errs, firstErr;

   always #5 clk = ~clk;

   // Mode 0 is a correct multiplier; 1 drops the sign bit; 2 returns -0 for
   // every zero product; 3 corrupts only the (+3, +3) result.
   function automatic logic [4:0] tbMul(input logic [2:0] a, input logic [2:0] b, input int m);
      int av, bv, p, mag;
      logic [4:0] r;
      av = a[2] ? -int'(a[1:0]) : int'(a[1:0]);
      bv = b[2] ? -int'(b[1:0]) : int'(b[1:0]);
      p = av * bv;
      mag = (p < 0) ? -p : p;
      r = sm5_pack(p < 0, 4'(mag));
      case (m)
         1: r[4] = 1'b0;
         2: if (mag == 0) r = 5'b10000;
         3: if (a == 3'b011 && b == 3'b011) r = 5'b01000;
         default: ;
      endcase
      return r;
   endfunction

   always_comb r1 = tbMul(a1, b1, mode);
   always_comb r2 = tbMul(a2, b2, mode);

   mul_sweep_checker #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a_out(a1), .b_out(b1), .r_in(r1),
      .busy(busy1), .done(done1), .err_pulse(err1), .pass_cnt(pass1), .fail_cnt(fail1),
      .first_fail(first1)
   );

   mul_sweep_checker #(.SETTLE_CYCLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a_out(a2), .b_out(b2), .r_in(r2),
      .busy(busy2), .done(done2), .err_pulse(err2), .pass_cnt(pass2), .fail_cnt(fail2),
      .first_fail(first2)
   );

   always_comb begin
      selA     = (sel == 1) ? a1 : a2;
      selB     = (sel == 1) ? b1 : b2;
      selBusy  = (sel == 1) ? busy1 : busy2;
      selDone  = (sel == 1) ? done1 : done2;
      selErr   = (sel == 1) ? err1 : err2;
      selPass  = (sel == 1) ? pass1 : pass2;
      selFail  = (sel == 1) ? fail1 : fail2;
      selFirst = (sel == 1) ? first1 : first2;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecCount++;
      if (obs !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic setStart(input logic v);
      if (sel == 1) start1 = v;
      else start2 = v;
   endtask

   // Pulses start on the selected instance and counts edges until done.
   // restartAt > 0 re-pulses start that many edges into the sweep.
   task automatic applyStimulus(input int restartAt, output int nEdges, output int nErr,
                                output int errEdge);
      int n;
      @(negedge clk);
      setStart(1'b1);
      @(posedge clk);
      #1;
      setStart(1'b0);
      checkOutput("startBusy", selBusy, 1);
      checkOutput("startDone", selDone, 0);
      checkOutput("startA", selA, 3'b111);
      checkOutput("startB", selB, 3'b111);
      checkOutput("startPass", selPass, 0);
      checkOutput("startFail", selFail, 0);
      checkOutput("startFirst", selFirst, 0);
      nErr = 0;
      errEdge = -1;
      n = 0;
      while (n < 1000) begin
         @(posedge clk);
         #1;
         n++;
         setStart(1'b0);
         if (selErr) begin
            nErr++;
            if (errEdge < 0) errEdge = n;
         end
         if (selDone) break;
         if (n == restartAt) setStart(1'b1);
      end
      setStart(1'b0);
      if (!selDone) checkOutput("sweepTimeout", 0, 1);
      nEdges = n;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "A"}, a2, 0);
      checkOutput({tag, "B"}, b2, 0);
      checkOutput({tag, "Busy"}, busy2, 0);
      checkOutput({tag, "Done"}, done2, 0);
      checkOutput({tag, "Err"}, err2, 0);
      checkOutput({tag, "Pass"}, pass2, 0);
      checkOutput({tag, "Fail"}, fail2, 0);
      checkOutput({tag, "First"}, first2, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkResetValues("rst");
      checkOutput("rstDone1", done1, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Correct multiplier, with a stray start 20 edges in that must be ignored.
      mode = 0;
      sel = 2;
      applyStimulus(20, len, errs, firstErr);
      checkOutput("okLen", len, 147);
      checkOutput("okPass", pass2, 49);
      checkOutput("okFail", fail2, 0);
      checkOutput("okFirst", first2, 0);
      checkOutput("okErrs", errs, 0);
      checkOutput("okBusy", busy2, 0);

      // Sign bit stuck at 0: every mixed-sign non-zero pair fails.
      mode = 1;
      applyStimulus(0, len, errs, firstErr);
      checkOutput("signLen", len, 147);
      checkOutput("signPass", pass2, 31);
      checkOutput("signFail", fail2, 18);
      checkOutput("signFirst", first2, 11'b111_001_00011);
      checkOutput("signErrs", errs, 18);
      checkOutput("signErrEdge", firstErr, 15);

      // Negative zero must be accepted.
      mode = 2;
      applyStimulus(0, len, errs, firstErr);
      checkOutput("zeroPass", pass2, 49);
      checkOutput("zeroFail", fail2, 0);
      checkOutput("zeroErrs", errs, 0);

      // Only the final pair is wrong.
      mode = 3;
      applyStimulus(0, len, errs, firstErr);
      checkOutput("lastPass", pass2, 48);
      checkOutput("lastFail", fail2, 1);
      checkOutput("lastFirst", first2, 11'b011_011_01000);
      checkOutput("lastErrEdge", firstErr, 147);
      checkOutput("lastDone", done2, 1);

      // Asynchronous reset 40 cycles into a sweep.
      mode = 0;
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      repeat (39) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkResetValues("abort");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abortIdleDone", done2, 0);
      applyStimulus(0, len, errs, firstErr);
      checkOutput("afterAbortLen", len, 147);
      checkOutput("afterAbortPass", pass2, 49);

      // Settle of one cycle, swept twice back to back from DONE.
      sel = 1;
      applyStimulus(0, len, errs, firstErr);
      checkOutput("s1Len", len, 98);
      checkOutput("s1Pass", pass1, 49);
      checkOutput("s1Fail", fail1, 0);
      applyStimulus(0, len, errs, firstErr);
      checkOutput("s1AgainLen", len, 98);
      checkOutput("s1AgainPass", pass1, 49);
      checkOutput("s1AgainDone", done1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/mul_sweep_checker.md
# mul_sweep_checker

Self-checking operand sequencer that sits directly upstream of the 3-bit sign-magnitude multiplier in the ALU datapath. On `start` it drives every operand pair A, B ∈ {−3…+3} into the multiplier. It samples the multiplier's 5-bit result after a programmable settle time and compares it against an internal golden product. It reports pass/fail counts and the first failing vector. It is the on-chip equivalent of the multiplier sweep and is used for power-on self-test of the ALU.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles each operand pair is held before the result is sampled. Legal range is 1–15.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin a sweep. Sampled only in IDLE or DONE.
- `a_out`, out, 3: operand A to the multiplier. Sign-magnitude: bit 2 is the sign, bits 1:0 are the magnitude.
- `b_out`, out, 3: operand B to the multiplier, same encoding as `a_out`.
- `r_in`, in, 5: multiplier result. Bit 4 is the sign, bits 3:0 are the magnitude (0–9).
- `busy`, out, 1: high while a sweep is in progress.
- `done`, out, 1: high from sweep completion until the next `start` or reset.
- `err_pulse`, out, 1: single-cycle pulse on each mismatching CHECK cycle.
- `pass_cnt`, out, 6: number of matching pairs.
- `fail_cnt`, out, 6: number of mismatching pairs.
- `first_fail`, out, 11: {A, B, R} of the first mismatch. Zero if there was none.

## Operation
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE → DRIVE on `start`:
  - Clear `pass_cnt`, `fail_cnt` and `first_fail`.
  - Load A = −3 (`111`) and B = −3 (`111`).
- DRIVE: hold `a_out`/`b_out` stable for `SETTLE_CYCLES` cycles using a down-counter. Go to CHECK when the counter reaches 0.
- CHECK: sample `r_in` and compare it with the golden value.
  - Golden value: sign = A[2] XOR B[2], magnitude = A[1:0] × B[1:0] (4-bit, maximum 9).
  - Zero rule: when the golden magnitude is 0, any `r_in` with `r_in[3:0]` = 0 matches, regardless of `r_in[4]`.
  - Match: increment `pass_cnt`.
  - Mismatch: increment `fail_cnt` and pulse `err_pulse`. Capture `first_fail` only if `fail_cnt` was 0.
- Sweep order:
  - B is the inner loop and steps −3, −2, −1, 0, +1, +2, +3.
  - A is the outer loop and advances in the same order.
  - Operand codes for that order: `111`, `110`, `101`, `000`, `001`, `010`, `011`.
  - Code `100` (−0) is never driven.
- After CHECK of (+3, +3): go to DONE. Otherwise advance the operands and return to DRIVE, reloading the settle counter.
- DONE:
  - Counters and `first_fail` hold their values.
  - `start` re-enters DRIVE with cleared counters, exactly as from IDLE.
- `start` while `busy` is high is ignored.

## Timing
- Reset values:
  - State is IDLE.
  - `a_out` = `b_out` = `000`.
  - `busy`, `done` and `err_pulse` are 0.
  - `pass_cnt`, `fail_cnt` and `first_fail` are 0.
- Reset asserted mid-sweep aborts the sweep immediately and asynchronously to the values above. No partial `done` is produced.
- `start` high at edge T:
  - `busy` and the first operands are visible after edge T.
  - The first CHECK occurs at edge T + `SETTLE_CYCLES` + 1.
- Each pair costs `SETTLE_CYCLES` + 1 cycles.
- A full sweep is 49 pairs, i.e. 49 × (`SETTLE_CYCLES` + 1) cycles. With the default, that is 147 cycles.
- `done` rises and `busy` falls on the same edge as the last CHECK's counter update.
- Counter updates and `err_pulse` are registered. They appear on the edge that ends the CHECK cycle.
- Counters never wrap: the maximum is 49, which fits in 6 bits.
- `r_in` is treated as combinational from `a_out`/`b_out`. `SETTLE_CYCLES` ≥ 1 guarantees at least one full cycle of settling.

## Structure
- Shared package `alu_pkg` holds:
  - the FSM state enum;
  - `MAG_MAX` = 3 and `NUM_PAIRS` = 49;
  - an operand-order constant array (7 × 3-bit codes);
  - a sign-magnitude helper function used by both the RTL and the bench.
- One sub-module, `mul_golden`: a combinational reference product. Inputs A and B (3-bit); outputs the expected 5-bit value and a zero flag.
- The top level contains the FSM, the settle counter, the two 3-bit index counters (0–6) and the result registers.

## Test plan
- Correct multiplier connected, `SETTLE_CYCLES` = 2, `start` pulsed → `done` after 147 cycles, `pass_cnt` = 49, `fail_cnt` = 0, `first_fail` = 0, no `err_pulse`.
- Multiplier stub that forces `r_in[4]` = 0 → `fail_cnt` = 18 (all mixed-sign pairs with non-zero magnitude), `pass_cnt` = 31, `first_fail` = {`111`, `001`, `00011`}.
- Stub that returns `10000` for every zero product → `pass_cnt` = 49 (zero rule).
- Reset asserted at cycle 40 of a sweep → all outputs return to their reset values in the same cycle; a subsequent `start` completes normally with 49 passes.
- `start` re-pulsed at cycle 20 while busy → ignored; sweep length is unchanged at 147 cycles.
- `SETTLE_CYCLES` = 1 → `done` after 98 cycles; `start` from DONE clears the counters and repeats the sweep.
